// File: rtl/palette_pkg.sv
// Shared types and constants for the nearest-color palette encoder.
package palette_pkg;

  localparam int PAL_SIZE = 16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef logic [3:0] pal_idx_t;
  typedef logic [5:0] dist_t;

  localparam dist_t DIST_MAX = 6'h3F;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_e;

  function automatic logic [3:0] absdiff4(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/palette_dist.sv
// Manhattan color distance between two 12-bit RGB values; range 0..45.
module palette_dist
  import palette_pkg::*;
(
  input  rgb12_t a_i,
  input  rgb12_t b_i,
  output dist_t  dist_o
);

  assign dist_o = dist_t'(absdiff4(a_i.r, b_i.r))
                + dist_t'(absdiff4(a_i.g, b_i.g))
                + dist_t'(absdiff4(a_i.b, b_i.b));

endmodule

// File: rtl/palette_encoder.sv
// Sequential nearest-color encoder: scans a programmable 16-entry palette
// one entry per cycle and returns the index with the smallest distance.
module palette_encoder
  import palette_pkg::*;
#(
  parameter int PAL_SIZE = palette_pkg::PAL_SIZE
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pal_we,
  input  logic [3:0]  pal_waddr,
  input  logic [11:0] pal_wdata,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_rgb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_index,
  output logic [5:0]  out_dist
);

  state_e   state_q, state_d;
  rgb12_t   pal_q [PAL_SIZE];
  rgb12_t   rgb_q, rgb_d;
  pal_idx_t cnt_q, cnt_d;
  pal_idx_t best_idx_q, best_idx_d;
  dist_t    best_dist_q, best_dist_d;
  pal_idx_t out_idx_q, out_idx_d;
  dist_t    out_dist_q, out_dist_d;

  dist_t    cur_dist;
  pal_idx_t cand_idx;
  dist_t    cand_dist;

  palette_dist u_dist (
    .a_i    (rgb_q),
    .b_i    (pal_q[cnt_q]),
    .dist_o (cur_dist)
  );

  // Palette storage: writes land at any time, so a write during a search
  // is only seen by entries the scan has not reached yet.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < PAL_SIZE; i++) begin
        pal_q[i] <= rgb12_t'({i[3:0], i[3:0], i[3:0]});
      end
    end else if (pal_we) begin
      pal_q[pal_waddr] <= rgb12_t'(pal_wdata);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      rgb_q       <= '0;
      cnt_q       <= '0;
      best_idx_q  <= '0;
      best_dist_q <= DIST_MAX;
      out_idx_q   <= '0;
      out_dist_q  <= '0;
    end else begin
      state_q     <= state_d;
      rgb_q       <= rgb_d;
      cnt_q       <= cnt_d;
      best_idx_q  <= best_idx_d;
      best_dist_q <= best_dist_d;
      out_idx_q   <= out_idx_d;
      out_dist_q  <= out_dist_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rgb_d       = rgb_q;
    cnt_d       = cnt_q;
    best_idx_d  = best_idx_q;
    best_dist_d = best_dist_q;
    out_idx_d   = out_idx_q;
    out_dist_d  = out_dist_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    // Strict less-than keeps the earliest index on ties.
    cand_idx  = (cur_dist < best_dist_q) ? cnt_q : best_idx_q;
    cand_dist = (cur_dist < best_dist_q) ? cur_dist : best_dist_q;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          rgb_d       = rgb12_t'(in_rgb);
          cnt_d       = '0;
          best_idx_d  = '0;
          best_dist_d = DIST_MAX;
          state_d     = SEARCH;
        end
      end
      SEARCH: begin
        best_idx_d  = cand_idx;
        best_dist_d = cand_dist;
        if ((cur_dist == '0) || (cnt_q == pal_idx_t'(PAL_SIZE - 1))) begin
          out_idx_d  = cand_idx;
          out_dist_d = cand_dist;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + pal_idx_t'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_index = out_idx_q;
  assign out_dist  = out_dist_q;

endmodule

// File: tb/tb_palette_encoder.sv
// Directed bench for palette_encoder with a transaction-level reference model.
module tb_palette_encoder;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_waddr = '0;
  logic [11:0] pal_wdata = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_rgb = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_index;
  logic [5:0]  out_dist;

  always #5 Clk = ~Clk;

  palette_encoder #(.PAL_SIZE(16)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .pal_we    (pal_we),
    .pal_waddr (pal_waddr),
    .pal_wdata (pal_wdata),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rgb    (in_rgb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_dist  (out_dist)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference model: whole-palette search on a snapshot taken at accept time.
  logic [11:0] pal_m [16];
  logic [11:0] snap  [16];
  logic [11:0] m_rgb;
  bit          m_busy = 1'b0;
  int          cyc = 0, ta = 0, m_idx = 0, m_dist = 0, m_k = 0;

  function automatic int adiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int cdist(input logic [11:0] p, input logic [11:0] q);
    return adiff(int'(p[11:8]), int'(q[11:8])) + adiff(int'(p[7:4]), int'(q[7:4]))
         + adiff(int'(p[3:0]), int'(q[3:0]));
  endfunction

  task automatic model_search(input logic [11:0] rgb);
    int best;
    best  = 63;
    m_idx = 0;
    m_k   = 15;
    for (int i = 0; i < 16; i++) begin
      int d;
      d = cdist(snap[i], rgb);
      if (d < best) begin
        best  = d;
        m_idx = i;
      end
      if (d == 0) begin
        m_k = i;
        break;
      end
    end
    m_dist = best;
  endtask

  always @(posedge Clk) begin : model
    bit vb;
    vb  = m_busy && (cyc >= ta + 1 + m_k);
    cyc = cyc + 1;
    if (Reset) begin
      m_busy = 1'b0;
      for (int i = 0; i < 16; i++) pal_m[i] = {i[3:0], i[3:0], i[3:0]};
    end else begin
      if (pal_we) begin
        pal_m[pal_waddr] = pal_wdata;
        if (m_busy && (int'(pal_waddr) > cyc - ta - 1)) begin
          snap[pal_waddr] = pal_wdata;
          model_search(m_rgb);
        end
      end
      if (m_busy) begin
        if (vb && out_ready) m_busy = 1'b0;
      end else if (in_valid) begin
        m_busy = 1'b1;
        ta     = cyc;
        m_rgb  = in_rgb;
        snap   = pal_m;
        model_search(m_rgb);
      end
    end
  end

  always @(negedge Clk) begin : cmp
    bit ev;
    if (!Reset) begin
      ev = m_busy && (cyc >= ta + 1 + m_k);
      check("in_ready", int'(in_ready), int'(!m_busy));
      check("out_valid", int'(out_valid), int'(ev));
      if (ev) begin
        check("out_index", int'(out_index), m_idx);
        check("out_dist", int'(out_dist), m_dist);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pal_write(input logic [3:0] a, input logic [11:0] d);
    pal_we = 1'b1; pal_waddr = a; pal_wdata = d;
    tick();
    pal_we = 1'b0;
  endtask

  task automatic wait_res(input string nm, input int e_idx, input int e_dist,
                          input int e_lat, input int n0);
    int n;
    n = n0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({nm, "_lat"}, n + 1, e_lat);
    check({nm, "_idx"}, int'(out_index), e_idx);
    check({nm, "_dist"}, int'(out_dist), e_dist);
  endtask

  task automatic run_pix(input string nm, input logic [11:0] rgb, input int e_idx,
                         input int e_dist, input int e_lat, input bit rdy);
    in_valid = 1'b1; in_rgb = rgb; out_ready = rdy;
    tick();
    in_valid = 1'b0;
    wait_res(nm, e_idx, e_dist, e_lat, 0);
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, "_in_ready"}, int'(in_ready), 1);
    check({nm, "_out_valid"}, int'(out_valid), 0);
    check({nm, "_out_index"}, int'(out_index), 0);
    check({nm, "_out_dist"}, int'(out_dist), 0);
  endtask

  initial begin
    repeat (3) tick();
    Reset = 1'b0;
    check_reset_state("rst");

    run_pix("gray7A7", 12'h7A7, 7, 3, 17, 1'b1);
    tick();
    check("gray7A7_one_cycle", int'(out_valid), 0);
    check("gray7A7_ready_back", int'(in_ready), 1);

    run_pix("early333", 12'h333, 3, 0, 5, 1'b1);
    tick();

    pal_write(4'd5, 12'hE00);
    pal_write(4'd9, 12'hE00);
    run_pix("tieF00", 12'hF00, 5, 1, 17, 1'b1);
    tick();

    // Stall the consumer; a new pixel must wait for the handshake.
    run_pix("stall", 12'h7A7, 7, 3, 17, 1'b0);
    in_valid = 1'b1; in_rgb = 12'h333;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stall_valid", int'(out_valid), 1);
      check("stall_idx", int'(out_index), 7);
      check("stall_dist", int'(out_dist), 3);
      check("stall_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    check("hs_in_ready", int'(in_ready), 1);
    check("hs_out_valid", int'(out_valid), 0);
    tick();
    in_valid = 1'b0;
    check("next_accepted", int'(in_ready), 0);
    wait_res("next333", 3, 0, 5, 0);
    tick();

    // Entry 12 rewritten during cycle T+5 of the search.
    in_valid = 1'b1; in_rgb = 12'h123; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    pal_we = 1'b1; pal_waddr = 4'd12; pal_wdata = 12'h123;
    tick();
    pal_we = 1'b0;
    wait_res("midwrite", 12, 0, 14, 5);
    tick();

    // Reset in the middle of a search.
    in_valid = 1'b1; in_rgb = 12'h7A7;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    Reset = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    check_reset_state("midrst");
    repeat (20) tick();
    check("midrst_no_valid", int'(out_valid), 0);

    run_pix("ramp555", 12'h555, 5, 0, 7, 1'b1);
    tick();
    run_pix("ramp123", 12'h123, 2, 2, 17, 1'b1);
    tick();
    run_pix("post7A7", 12'h7A7, 7, 3, 17, 1'b1);
    tick();
    run_pix("first000", 12'h000, 0, 0, 2, 1'b1);
    tick();
    check("ii_ready", int'(in_ready), 1);
    run_pix("lastFFF", 12'hFFF, 15, 0, 17, 1'b1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
